l1_refill_ctrl: RTL and testbench
=================================

// Module: l1_refill_ctrl
// PURPOSE
//  Sequencer between a single CPU requester, the 4-way L1 cache and the L2/memory port.
//  Accepts one read at a time, probes L1, and on a miss fetches the word from L2 with a req/ack handshake.
//  Promotes the fetched word into L1 via write_enable, then returns the data to the CPU.
//  Provides a bounded memory wait (timeout -> error response) so a dead L2 cannot hang the core.
// PARAMETERS
//  ADDR_WIDTH   11   address width, shared by the CPU, L1 and L2 ports
//  DATA_WIDTH   32   data word width
//  MEM_TIMEOUT  64   max cycles in MEM_WAIT before error; legal range 1..65535
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           asynchronous reset, active-high
//  cpu_req       in   1           read request; qualified by cpu_ready
//  cpu_addr      in   ADDR_WIDTH  request address; sampled on accept
//  cpu_ready     out  1           controller idle, can accept a request
//  rsp_valid     out  1           one-cycle response strobe
//  rsp_data      out  DATA_WIDTH  response data; valid with rsp_valid
//  rsp_err       out  1           response is a timeout error; valid with rsp_valid
//  l1_read       out  1           L1 read strobe
//  l1_write_en   out  1           L1 promote strobe
//  l1_addr       out  ADDR_WIDTH  L1 address (latched request address)
//  l1_wdata      out  DATA_WIDTH  L1 promote data
//  l1_rdata      in   DATA_WIDTH  L1 registered read data
//  l1_hit        in   1           L1 registered hit flag
//  mem_req       out  1           L2 request, level; held until mem_ack
//  mem_addr      out  ADDR_WIDTH  L2 address (latched request address)
//  mem_ack       in   1           L2 data-valid strobe
//  mem_rdata     in   DATA_WIDTH  L2 data; valid with mem_ack
// BEHAVIOUR
//  Reset (async): state=IDLE, addr/data regs=0, timer=0.
//   Outputs: cpu_ready=1; all other outputs 0.
//  All outputs decode from registered state/regs; there is no combinational input->output path.
//  FSM:
//   IDLE:   cpu_ready=1; cpu_req=1 -> latch cpu_addr, go to LOOKUP. cpu_req is ignored in all other states.
//   LOOKUP: l1_read=1 for exactly 1 cycle -> CHECK.
//   CHECK:  sample l1_hit/l1_rdata (L1 output is registered one edge after l1_read).
//           hit -> latch l1_rdata, go to RESP. miss -> clear timer, go to MEM_WAIT.
//   MEM_WAIT: mem_req=1; timer increments each cycle.
//           mem_ack=1 -> latch mem_rdata, go to FILL (mem_req drops the next cycle).
//           Otherwise, timer==MEM_TIMEOUT-1 -> data=0, err=1, go to RESP; no L1 fill.
//           mem_ack on the same cycle as the timeout -> ack wins.
//   FILL:   l1_write_en=1, l1_wdata=fetched word for 1 cycle -> RESP.
//   RESP:   rsp_valid=1 for 1 cycle, plus rsp_data and rsp_err -> IDLE.
//  Outside RESP: rsp_data=0 and rsp_err=0. A new request is accepted the cycle after RESP.
//  Latency (accept edge = cycle 0):
//   hit -> rsp_valid in cycle 3.
//   miss with mem_ack in the first MEM_WAIT cycle -> rsp_valid in cycle 5; each extra wait cycle adds 1.
//  l1_addr and mem_addr hold the latched address from accept until IDLE; they are 0 only after reset.
//  A stray mem_ack outside MEM_WAIT is ignored.
//  rst asserted mid-transaction: immediate IDLE, no response. mem_req drops asynchronously.
//  The timer width is 16 bits; it never wraps because it exits at MEM_TIMEOUT-1.
// CONFIGURATION
//  L1CTRL_STATS_EN defined:
//   adds outputs stat_hits, stat_misses, stat_timeouts (32-bit each).
//   Counters increment on the CHECK-hit, CHECK-miss and timeout transitions respectively.
//   Counters saturate at all-ones and are cleared by rst.
//  L1CTRL_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  Reset: assert rst mid-cycle -> cpu_ready=1, mem_req=0, rsp_valid=0 immediately, without waiting for clk.
//  Hit: req addr 0x123 with the L1 model returning hit=1, data 0xCAFEF00D
//   -> l1_read in cycle 1; rsp_valid in cycle 3 with data 0xCAFEF00D, err=0; mem_req never asserted.
//  Miss: req 0x040, L1 hit=0, L2 acks after 3 cycles with 0x12345678
//   -> mem_addr=0x040; l1_write_en pulses with wdata 0x12345678; rsp_valid in cycle 8 with data 0x12345678.
//  Timeout: MEM_TIMEOUT=4, never ack -> mem_req high for exactly 4 cycles, no l1_write_en, rsp_err=1, rsp_data=0.
//  Back-to-back/boundary: cpu_req held high across 2 requests -> second accepted the cycle after RESP.
//   mem_ack on the final timeout cycle -> normal fill, err=0.
//  Abort: rst during MEM_WAIT, then new req 0x7FF -> no stale rsp_valid; the new request completes normally.
//   With L1CTRL_STATS_EN: 2 hits, 1 miss, 1 timeout -> counters read 2/2/1.

Source files
------------

// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl
//   Read sequencer between one CPU requester, a 4-way L1 cache and the
//   L2/memory port. One read is in flight at a time: the L1 is probed, a
//   miss is fetched from L2 with a level req / strobe ack handshake, the
//   fetched word is promoted into L1 and finally returned to the CPU.
//   A bounded memory wait turns a dead L2 into an error response.
//
//   Optional build macro: L1CTRL_STATS_EN adds saturating hit / miss /
//   timeout counters (stat_hits, stat_misses, stat_timeouts).
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   cpu_req/cpu_addr  read request and address (taken only while idle)
//   cpu_ready         controller idle, request will be accepted
//   rsp_valid/data/err one-cycle response strobe, data and timeout flag
//   l1_read           L1 probe strobe
//   l1_write_en/wdata L1 promote strobe and data
//   l1_addr           latched request address towards L1
//   l1_rdata/l1_hit   registered L1 read data and hit flag
//   mem_req/mem_addr  L2 request (level, held until ack) and address
//   mem_ack/mem_rdata L2 data-valid strobe and data
//
// Every output is decoded from registered state, so no input reaches an
// output combinationally and reset takes effect on the outputs at once.
module l1_refill_ctrl #(
   parameter int ADDR_WIDTH  = 11,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic                  cpu_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  l1_read,
   output logic                  l1_write_en,
   output logic [ADDR_WIDTH-1:0] l1_addr,
   output logic [DATA_WIDTH-1:0] l1_wdata,
   input  logic [DATA_WIDTH-1:0] l1_rdata,
   input  logic                  l1_hit,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef L1CTRL_STATS_EN
   ,
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses,
   output logic [31:0]           stat_timeouts
`endif
);

   // Last timer value before giving up; the wait lasts MEM_TIMEOUT cycles.
   localparam logic [15:0] TIMER_LAST = 16'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_CHECK,
      S_MEM_WAIT,
      S_FILL,
      S_RESP
   } state_t;

   state_t                  state_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [DATA_WIDTH-1:0]   data_reg;
   logic                    err_reg;
   logic [15:0]             timer_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         addr_reg  <= '0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
         timer_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cpu_req) begin
                  addr_reg  <= cpu_addr;
                  data_reg  <= '0;
                  err_reg   <= 1'b0;
                  state_reg <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               state_reg <= S_CHECK;
            end
            S_CHECK: begin
               // L1 answers one edge after the probe strobe.
               if (l1_hit) begin
                  data_reg  <= l1_rdata;
                  state_reg <= S_RESP;
               end else begin
                  timer_reg <= '0;
                  state_reg <= S_MEM_WAIT;
               end
            end
            S_MEM_WAIT: begin
               // An ack on the last allowed cycle still wins over the timeout.
               if (mem_ack) begin
                  data_reg  <= mem_rdata;
                  state_reg <= S_FILL;
               end else if (timer_reg == TIMER_LAST) begin
                  data_reg  <= '0;
                  err_reg   <= 1'b1;
                  state_reg <= S_RESP;
               end else begin
                  timer_reg <= timer_reg + 16'd1;
               end
            end
            S_FILL: begin
               state_reg <= S_RESP;
            end
            S_RESP: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign cpu_ready   = (state_reg == S_IDLE);
   assign l1_read     = (state_reg == S_LOOKUP);
   assign l1_write_en = (state_reg == S_FILL);
   assign mem_req     = (state_reg == S_MEM_WAIT);
   assign rsp_valid   = (state_reg == S_RESP);
   assign rsp_data    = (state_reg == S_RESP) ? data_reg : '0;
   assign rsp_err     = (state_reg == S_RESP) ? err_reg  : 1'b0;
   assign l1_wdata    = (state_reg == S_FILL) ? data_reg : '0;
   assign l1_addr     = addr_reg;
   assign mem_addr    = addr_reg;

`ifdef L1CTRL_STATS_EN
   logic ev_hit;
   logic ev_miss;
   logic ev_timeout;

   assign ev_hit     = (state_reg == S_CHECK) &&  l1_hit;
   assign ev_miss    = (state_reg == S_CHECK) && !l1_hit;
   assign ev_timeout = (state_reg == S_MEM_WAIT) && !mem_ack && (timer_reg == TIMER_LAST);

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_hits     <= '0;
         stat_misses   <= '0;
         stat_timeouts <= '0;
      end else begin
         if (ev_hit && (stat_hits != '1))
            stat_hits <= stat_hits + 32'd1;
         if (ev_miss && (stat_misses != '1))
            stat_misses <= stat_misses + 32'd1;
         if (ev_timeout && (stat_timeouts != '1))
            stat_timeouts <= stat_timeouts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl built with MEM_TIMEOUT=4.
// Cycle numbering: cycle 0 is the cycle in which cpu_req is seen in IDLE,
// so cycle 1 follows the accept edge. Outputs are sampled 1 time unit
// after each rising edge.
module tb_l1_refill_ctrl;

   localparam int AW = 11;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          l1_read;
   logic          l1_write_en;
   logic [AW-1:0] l1_addr;
   logic [DW-1:0] l1_wdata;
   logic [DW-1:0] l1_rdata = '0;
   logic          l1_hit = 1'b0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
`ifdef L1CTRL_STATS_EN
   logic [31:0]   stat_hits;
   logic [31:0]   stat_misses;
   logic [31:0]   stat_timeouts;
`endif

   // L1 model: registers the configured hit/data one edge after l1_read.
   logic          m_hit;
   logic [DW-1:0] m_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (l1_read) begin
         l1_hit   <= m_hit;
         l1_rdata <= m_data;
      end
   end

   l1_refill_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_TIMEOUT(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_ready  (cpu_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .l1_read    (l1_read),
      .l1_write_en(l1_write_en),
      .l1_addr    (l1_addr),
      .l1_wdata   (l1_wdata),
      .l1_rdata   (l1_rdata),
      .l1_hit     (l1_hit),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
`ifdef L1CTRL_STATS_EN
      ,
      .stat_hits    (stat_hits),
      .stat_misses  (stat_misses),
      .stat_timeouts(stat_timeouts)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b0;
      cpu_req   = 1'b0;
      cpu_addr  = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      m_hit     = 1'b0;
      m_data    = '0;

      // ---- Reset asserted mid-cycle, checked before any clock edge ----
      #2 rst = 1'b1;
      #1;
      chk("rst_cpu_ready", cpu_ready, 1);
      chk("rst_mem_req",   mem_req,   0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_l1_addr",   l1_addr,   0);
      tick();
      rst = 1'b0;
      tick();
      $display("reset: cpu_ready=%0d mem_req=%0d rsp_valid=%0d", cpu_ready, mem_req, rsp_valid);

      // ---- Hit: addr 0x123, L1 returns 0xCAFEF00D ----
      m_hit = 1'b1; m_data = 32'hCAFEF00D;
      cpu_addr = 11'h123; cpu_req = 1'b1;
      chk("hit_c0_ready", cpu_ready, 1);
      tick(); cpu_req = 1'b0;                                  // cycle 1
      chk("hit_c1_l1_read", l1_read, 1);
      chk("hit_c1_l1_addr", l1_addr, 11'h123);
      chk("hit_c1_ready",   cpu_ready, 0);
      chk("hit_c1_mem_req", mem_req, 0);
      tick();                                                  // cycle 2
      chk("hit_c2_l1_read", l1_read, 0);
      chk("hit_c2_rsp",     rsp_valid, 0);
      chk("hit_c2_mem_req", mem_req, 0);
      tick();                                                  // cycle 3
      chk("hit_c3_rsp",     rsp_valid, 1);
      chk("hit_c3_data",    rsp_data, 32'hCAFEF00D);
      chk("hit_c3_err",     rsp_err, 0);
      chk("hit_c3_mem_req", mem_req, 0);
      tick();                                                  // cycle 4
      chk("hit_c4_ready",   cpu_ready, 1);
      chk("hit_c4_rsp",     rsp_valid, 0);
      chk("hit_c4_data",    rsp_data, 0);
      $display("hit: addr=123 data=%h", 32'hCAFEF00D);

      // ---- Miss: addr 0x040, ack in 4th wait cycle (also the final
      //      timeout cycle with MEM_TIMEOUT=4, so ack must win) ----
      m_hit = 1'b0; m_data = 32'hDEADBEEF;
      cpu_addr = 11'h040; cpu_req = 1'b1;
      tick(); cpu_req = 1'b0;                                  // cycle 1
      chk("miss_c1_l1_read", l1_read, 1);
      tick();                                                  // cycle 2
      chk("miss_c2_mem_req", mem_req, 0);
      tick();                                                  // cycle 3
      chk("miss_c3_mem_req",  mem_req, 1);
      chk("miss_c3_mem_addr", mem_addr, 11'h040);
      tick();                                                  // cycle 4
      chk("miss_c4_mem_req", mem_req, 1);
      tick();                                                  // cycle 5
      chk("miss_c5_mem_req", mem_req, 1);
      tick();                                                  // cycle 6
      chk("miss_c6_mem_req", mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();                                                  // cycle 7
      mem_ack = 1'b0; mem_rdata = '0;
      chk("miss_c7_mem_req", mem_req, 0);
      chk("miss_c7_wen",     l1_write_en, 1);
      chk("miss_c7_wdata",   l1_wdata, 32'h12345678);
      chk("miss_c7_rsp",     rsp_valid, 0);
      tick();                                                  // cycle 8
      chk("miss_c8_rsp",   rsp_valid, 1);
      chk("miss_c8_data",  rsp_data, 32'h12345678);
      chk("miss_c8_err",   rsp_err, 0);
      chk("miss_c8_wen",   l1_write_en, 0);
      tick();
      chk("miss_c9_ready", cpu_ready, 1);
      $display("miss: addr=040 data=%h (ack on last wait cycle)", 32'h12345678);

      // ---- Timeout: never ack, mem_req high for exactly 4 cycles ----
      m_hit = 1'b0;
      cpu_addr = 11'h0AA; cpu_req = 1'b1;
      tick(); cpu_req = 1'b0;                                  // cycle 1
      tick();                                                  // cycle 2
      chk("to_c2_mem_req", mem_req, 0);
      tick();                                                  // cycle 3
      for (int c = 3; c <= 6; c++) begin
         chk("to_wait_mem_req", mem_req, 1);
         chk("to_wait_wen",     l1_write_en, 0);
         tick();
      end                                                      // cycle 7
      chk("to_c7_mem_req", mem_req, 0);
      chk("to_c7_wen",     l1_write_en, 0);
      chk("to_c7_rsp",     rsp_valid, 1);
      chk("to_c7_err",     rsp_err, 1);
      chk("to_c7_data",    rsp_data, 0);
      // Stray ack outside MEM_WAIT must be ignored.
      mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      tick();                                                  // cycle 8
      chk("stray_c8_ready", cpu_ready, 1);
      chk("stray_c8_err",   rsp_err, 0);
      tick();                                                  // cycle 9
      mem_ack = 1'b0; mem_rdata = '0;
      chk("stray_c9_ready", cpu_ready, 1);
      chk("stray_c9_wen",   l1_write_en, 0);
      chk("stray_c9_lread", l1_read, 0);
      $display("timeout: addr=0AA rsp_err=1 rsp_data=0");

      // ---- Back-to-back: cpu_req held high over two requests ----
      m_hit = 1'b1; m_data = 32'h11111111;
      cpu_addr = 11'h200; cpu_req = 1'b1;
      tick();                                                  // cycle 1
      chk("b2b_c1_l1_addr", l1_addr, 11'h200);
      tick();                                                  // cycle 2
      cpu_addr = 11'h201;                                      // ignored while busy
      m_data = 32'h22222222;
      tick();                                                  // cycle 3
      chk("b2b_c3_rsp",     rsp_valid, 1);
      chk("b2b_c3_data",    rsp_data, 32'h11111111);
      chk("b2b_c3_l1_addr", l1_addr, 11'h200);
      tick();                                                  // cycle 4
      chk("b2b_c4_ready",   cpu_ready, 1);
      chk("b2b_c4_rsp",     rsp_valid, 0);
      tick(); cpu_req = 1'b0;                                  // cycle 5
      chk("b2b_c5_l1_read", l1_read, 1);
      chk("b2b_c5_l1_addr", l1_addr, 11'h201);
      tick();                                                  // cycle 6
      tick();                                                  // cycle 7
      chk("b2b_c7_rsp",     rsp_valid, 1);
      chk("b2b_c7_data",    rsp_data, 32'h22222222);
      tick();
      $display("back-to-back: 200 -> %h, 201 -> %h", 32'h11111111, 32'h22222222);

`ifdef L1CTRL_STATS_EN
      chk("stat_hits",     stat_hits, 3);
      chk("stat_misses",   stat_misses, 2);
      chk("stat_timeouts", stat_timeouts, 1);
`endif

      // ---- Abort: reset during MEM_WAIT, then new request 0x7FF ----
      m_hit = 1'b0;
      cpu_addr = 11'h155; cpu_req = 1'b1;
      tick(); cpu_req = 1'b0;                                  // cycle 1
      tick();                                                  // cycle 2
      tick();                                                  // cycle 3
      chk("abort_c3_mem_req", mem_req, 1);
      #3 rst = 1'b1;
      #1;
      chk("abort_mem_req", mem_req, 0);
      chk("abort_ready",   cpu_ready, 1);
      chk("abort_rsp",     rsp_valid, 0);
      chk("abort_l1_addr", l1_addr, 0);
      #1 rst = 1'b0;
      tick();
      chk("abort_post_rsp", rsp_valid, 0);
`ifdef L1CTRL_STATS_EN
      chk("stat_clr_hits", stat_hits, 0);
`endif
      cpu_addr = 11'h7FF; cpu_req = 1'b1;
      tick(); cpu_req = 1'b0;                                  // cycle 1
      chk("new_c1_rsp",     rsp_valid, 0);
      chk("new_c1_l1_read", l1_read, 1);
      tick();                                                  // cycle 2
      chk("new_c2_rsp",     rsp_valid, 0);
      tick();                                                  // cycle 3
      chk("new_c3_mem_addr", mem_addr, 11'h7FF);
      chk("new_c3_mem_req",  mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'hA5A55A5A;
      tick();                                                  // cycle 4
      mem_ack = 1'b0; mem_rdata = '0;
      chk("new_c4_wen",   l1_write_en, 1);
      chk("new_c4_wdata", l1_wdata, 32'hA5A55A5A);
      tick();                                                  // cycle 5
      chk("new_c5_rsp",  rsp_valid, 1);
      chk("new_c5_data", rsp_data, 32'hA5A55A5A);
      chk("new_c5_err",  rsp_err, 0);
      tick();
      $display("abort: reset in MEM_WAIT, then addr=7FF data=%h", 32'hA5A55A5A);

`ifdef L1CTRL_STATS_EN
      chk("stat2_hits",     stat_hits, 0);
      chk("stat2_misses",   stat_misses, 1);
      chk("stat2_timeouts", stat_timeouts, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
